seg7_stream_rx: RTL and testbench

SEG7_STREAM_RX -- requirements
Module: seg7_stream_rx

---
 rtl/seg7_pkg.sv | 61 ++++++
 rtl/seg7_decode.sv | 31 +++
 rtl/seg7_stream_rx.sv | 171 +++++++++++++++++
 tb/tb_seg7_stream_rx.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: symbol codes, segment patterns ({dp,g,f,e,d,c,b,a})
// and the receive frame state type; used by both the display transmitter and receiver.
package seg7_pkg;

  localparam logic [3:0] SYM_BLANK   = 4'hA;
  localparam logic [3:0] SYM_V       = 4'hB;
  localparam logic [3:0] SYM_E       = 4'hC;
  localparam logic [3:0] SYM_R       = 4'hD;
  localparam logic [3:0] SYM_DASH    = 4'hE;
  localparam logic [3:0] SYM_INVALID = 4'hF;

  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_V     = 8'h3E;
  localparam logic [7:0] SEG_E     = 8'h79;
  localparam logic [7:0] SEG_R     = 8'h50;
  localparam logic [7:0] SEG_DASH  = 8'h40;

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    GET1 = 3'd1,
    GET2 = 3'd2,
    GET3 = 3'd3,
    GET4 = 3'd4
  } frame_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  // Encoder side of the link; invalid codes are shown as a dash.
  function automatic logic [7:0] sym_to_seg(input logic [3:0] code);
    case (code)
      4'd0:      return SEG_0;
      4'd1:      return SEG_1;
      4'd2:      return SEG_2;
      4'd3:      return SEG_3;
      4'd4:      return SEG_4;
      4'd5:      return SEG_5;
      4'd6:      return SEG_6;
      4'd7:      return SEG_7;
      4'd8:      return SEG_8;
      4'd9:      return SEG_9;
      SYM_BLANK: return SEG_BLANK;
      SYM_V:     return SEG_V;
      SYM_E:     return SEG_E;
      SYM_R:     return SEG_R;
      default:   return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern to symbol-code decoder; unknown patterns map to SYM_INVALID.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] code
);

  always_comb begin
    code = SYM_INVALID;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = SYM_BLANK;
      SEG_V:     code = SYM_V;
      SEG_E:     code = SYM_E;
      SEG_R:     code = SYM_R;
      SEG_DASH:  code = SYM_DASH;
      default:   code = SYM_INVALID;
    endcase
  end

endmodule

// File: rtl/seg7_stream_rx.sv
// Recovers symbols and 4-digit score frames from a time-multiplexed seven-segment stream.
// Define SEG7_RX_OVER_EN to accept the 0-V-E-R "game over" frame on frame_over.
module seg7_stream_rx
  import seg7_pkg::*;
#(
  parameter int SLOT_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   seg_in,
  output logic         sym_valid,
  output logic [3:0]   sym_code,
  output logic         frame_valid,
  output logic [15:0]  frame_digits,
  output logic         frame_over,
  output logic         frame_err,
  output frame_state_t state_dbg
);

`ifdef SEG7_RX_OVER_EN
  localparam bit OVER_EN = 1'b1;
`else
  localparam bit OVER_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);

  // All outputs are single-cycle valid pulses with no ready/backpressure: a consumer
  // must take sym_code with sym_valid, and frame_digits is stable from frame_valid on.

  logic [7:0]       seg_q;
  logic [7:0]       seg_prev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_next;
  logic             slot_done;
  logic [3:0]       dec_code;

  seg7_decode u_decode (
    .seg  (seg_q),
    .code (dec_code)
  );

  // A pattern change restarts the slot in the very cycle it is seen.
  always_comb begin
    cnt_cur   = (seg_q != seg_prev) ? '0 : cnt;
    slot_done = (cnt_cur == SLOT_LAST);
    cnt_next  = slot_done ? '0 : cnt_cur + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q     <= 8'h00;
      seg_prev  <= 8'h00;
      cnt       <= '0;
      sym_valid <= 1'b0;
      sym_code  <= 4'h0;
    end else begin
      seg_q     <= seg_in;
      seg_prev  <= seg_q;
      cnt       <= cnt_next;
      sym_valid <= slot_done;
      if (slot_done) sym_code <= dec_code;
    end
  end

  frame_state_t state, state_n;
  logic         letters, letters_n;
  logic [3:0]   d1, d2, d3;
  logic [3:0]   d1_n, d2_n, d3_n;
  logic [15:0]  digits_n;
  logic         fire_valid, fire_over, fire_err;

  // letters marks a frame that began with 0 and continued V.. as an over frame.
  always_comb begin
    state_n    = state;
    letters_n  = letters;
    d1_n       = d1;
    d2_n       = d2;
    d3_n       = d3;
    digits_n   = frame_digits;
    fire_valid = 1'b0;
    fire_over  = 1'b0;
    fire_err   = 1'b0;
    if (sym_valid) begin
      if (sym_code == SYM_DASH) begin
        state_n = HUNT;
      end else begin
        case (state)
          HUNT: begin
            if (sym_code == SYM_BLANK) state_n = GET1;
          end
          GET1: begin
            if (sym_code == SYM_BLANK) begin
              state_n = GET1;
            end else if (is_digit(sym_code)) begin
              d1_n      = sym_code;
              letters_n = 1'b0;
              state_n   = GET2;
            end else begin
              fire_err = 1'b1;
            end
          end
          GET2: begin
            if (is_digit(sym_code)) begin
              d2_n    = sym_code;
              state_n = GET3;
            end else if (OVER_EN && sym_code == SYM_V && d1 == 4'd0) begin
              letters_n = 1'b1;
              state_n   = GET3;
            end else begin
              fire_err = 1'b1;
            end
          end
          GET3: begin
            if (is_digit(sym_code) && !letters) begin
              d3_n    = sym_code;
              state_n = GET4;
            end else if (OVER_EN && letters && sym_code == SYM_E) begin
              state_n = GET4;
            end else begin
              fire_err = 1'b1;
            end
          end
          GET4: begin
            if (is_digit(sym_code) && !letters) begin
              digits_n   = {d1, d2, d3, sym_code};
              fire_valid = 1'b1;
              state_n    = HUNT;
            end else if (OVER_EN && letters && sym_code == SYM_R) begin
              fire_over = 1'b1;
              state_n   = HUNT;
            end else begin
              fire_err = 1'b1;
            end
          end
          default: state_n = HUNT;
        endcase
        if (fire_err) state_n = HUNT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HUNT;
      letters      <= 1'b0;
      d1           <= 4'h0;
      d2           <= 4'h0;
      d3           <= 4'h0;
      frame_digits <= 16'h0000;
      frame_valid  <= 1'b0;
      frame_over   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state        <= state_n;
      letters      <= letters_n;
      d1           <= d1_n;
      d2           <= d2_n;
      d3           <= d3_n;
      frame_digits <= digits_n;
      frame_valid  <= fire_valid;
      frame_over   <= OVER_EN & fire_over;
      frame_err    <= fire_err;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_seg7_stream_rx.sv
// Bench for seg7_stream_rx with SLOT_CYCLES=4: directed scenarios plus random streams,
// checked every cycle against a symbol/frame model built from run lengths and a symbol queue.
module tb_seg7_stream_rx;
  import seg7_pkg::*;

  localparam int SLOT = 4;
`ifdef SEG7_RX_OVER_EN
  localparam bit OVER_EN = 1'b1;
`else
  localparam bit OVER_EN = 1'b0;
`endif

  // index = symbol code 0..14
  localparam logic [7:0] PAT_TAB [15] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D,
                                          8'h07, 8'h7F, 8'h6F, 8'h00, 8'h3E, 8'h79, 8'h50, 8'h40};
  localparam logic [3:0] OVER_SEQ [4] = '{4'h0, 4'hB, 4'hC, 4'hD};

  logic         clk;
  logic         rst_n;
  logic [7:0]   seg_in;
  logic         sym_valid;
  logic [3:0]   sym_code;
  logic         frame_valid;
  logic [15:0]  frame_digits;
  logic         frame_over;
  logic         frame_err;
  frame_state_t state_dbg;

  seg7_stream_rx #(.SLOT_CYCLES(SLOT), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_in       (seg_in),
    .sym_valid    (sym_valid),
    .sym_code     (sym_code),
    .frame_valid  (frame_valid),
    .frame_digits (frame_digits),
    .frame_over   (frame_over),
    .frame_err    (frame_err),
    .state_dbg    (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  logic [7:0]  cur_reg;
  int          run_len;
  logic        e_sv, e_fv, e_over, e_err;
  logic [3:0]  e_code;
  logic [15:0] e_digits;
  bit          hunting;
  logic [3:0]  fq[$];

  // observed pulse counters
  int n_sym = 0, n_sym8 = 0, n_fv = 0, n_over = 0, n_err = 0;
  int s_sym, s_sym8, s_fv, s_over, s_err;
  logic [3:0] last_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_decode(input logic [7:0] p);
    for (int i = 0; i < 15; i++) if (PAT_TAB[i] == p) return 4'(i);
    return 4'hF;
  endfunction

  // Frame rules over the queue of symbols collected after the leading blank.
  task automatic frame_step(input logic [3:0] c);
    bit all_dig, over_pfx;
    if (c == 4'hE) begin
      hunting = 1'b1;
      fq.delete();
    end else if (hunting) begin
      if (c == 4'hA) hunting = 1'b0;
    end else if (fq.size() == 0 && c == 4'hA) begin
      hunting = 1'b0;
    end else begin
      fq.push_back(c);
      all_dig  = 1'b1;
      over_pfx = OVER_EN;
      foreach (fq[i]) begin
        if (fq[i] > 4'd9) all_dig = 1'b0;
        if (fq[i] != OVER_SEQ[i]) over_pfx = 1'b0;
      end
      if (!all_dig && !over_pfx) begin
        e_err   = 1'b1;
        hunting = 1'b1;
        fq.delete();
      end else if (fq.size() == 4) begin
        if (all_dig) begin
          e_fv     = 1'b1;
          e_digits = {fq[0], fq[1], fq[2], fq[3]};
        end else begin
          e_over = 1'b1;
        end
        hunting = 1'b1;
        fq.delete();
      end
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      cur_reg  = 8'h00;
      run_len  = 1;
      e_sv     = 1'b0;
      e_code   = 4'h0;
      e_fv     = 1'b0;
      e_over   = 1'b0;
      e_err    = 1'b0;
      e_digits = 16'h0000;
      hunting  = 1'b1;
      fq.delete();
    end else begin
      e_fv   = 1'b0;
      e_over = 1'b0;
      e_err  = 1'b0;
      if (e_sv) frame_step(e_code);
      e_sv = 1'b0;
      if (run_len == SLOT) begin
        e_sv    = 1'b1;
        e_code  = m_decode(cur_reg);
        run_len = 0;
      end
      if (seg_in != cur_reg) run_len = 1;
      else run_len++;
      cur_reg = seg_in;
    end
  endtask

  task automatic compare_cycle();
    chk("sym_valid", sym_valid, e_sv);
    if (e_sv) chk("sym_code", sym_code, e_code);
    chk("frame_valid", frame_valid, e_fv);
    chk("frame_over", frame_over, e_over);
    chk("frame_err", frame_err, e_err);
    chk("frame_digits", frame_digits, e_digits);
    if (frame_valid && frame_over || frame_valid && frame_err || frame_over && frame_err)
      chk("pulse_exclusive", 1, 0);
    if (sym_valid) begin
      n_sym++;
      last_code = sym_code;
      if (sym_code == 4'd8) n_sym8++;
    end
    if (frame_valid) n_fv++;
    if (frame_over) n_over++;
    if (frame_err) n_err++;
  endtask

  task automatic drive(input logic [7:0] p, input int n);
    repeat (n) begin
      seg_in = p;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    seg_in = 8'h40;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic snap();
    s_sym  = n_sym;
    s_sym8 = n_sym8;
    s_fv   = n_fv;
    s_over = n_over;
    s_err  = n_err;
  endtask

  task automatic drive_codes(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic [7:0] e);
    drive(a, SLOT); drive(b, SLOT); drive(c, SLOT); drive(d, SLOT); drive(e, SLOT);
  endtask

  function automatic logic [7:0] rand_pat();
    int r;
    r = $urandom_range(0, 16);
    if (r < 15) return PAT_TAB[r];
    return 8'($urandom);
  endfunction

  initial begin
    logic [7:0]  seq [5];
    logic [15:0] held;
    int          k;
    rst_n  = 1'b0;
    seg_in = 8'h40;
    fork
      forever begin
        @(posedge clk);
        model_edge();
        #1;
        compare_cycle();
      end
    join_none

    @(negedge clk);
    do_reset();
    chk("reset_digits", frame_digits, 16'h0000);
    chk("reset_state", state_dbg, HUNT);
    drive(8'h40, 6);

    // score 1234
    snap();
    drive_codes(8'h00, 8'h06, 8'h5B, 8'h4F, 8'h66);
    drive(8'h40, 3);
    chk("t1234_fv_count", n_fv - s_fv, 1);
    chk("t1234_err_count", n_err - s_err, 0);
    chk("t1234_digits", frame_digits, 16'h1234);
    chk("t1234_model", e_digits, 16'h1234);
    drive(8'h40, 3);

    // a single pattern held for four slots gives four symbols
    snap();
    drive(8'h00, SLOT);
    drive(8'h6D, 4 * SLOT);
    drive(8'h40, 3);
    chk("t5555_sym_count", n_sym - s_sym, 5);
    chk("t5555_fv_count", n_fv - s_fv, 1);
    chk("t5555_digits", frame_digits, 16'h5555);
    drive(8'h40, 3);

`ifdef SEG7_RX_OVER_EN
    snap();
    drive_codes(8'h00, 8'h3F, 8'h3E, 8'h79, 8'h50);
    drive(8'h40, 3);
    chk("tover_count", n_over - s_over, 1);
    chk("tover_fv_count", n_fv - s_fv, 0);
    chk("tover_digits", frame_digits, 16'h5555);
    drive(8'h40, 3);
`endif

    // invalid pattern mid-frame
    snap();
    drive(8'h00, SLOT);
    drive(8'h07, SLOT);
    drive(8'h12, SLOT);
    drive(8'h40, 3);
    chk("terr_count", n_err - s_err, 1);
    chk("terr_state", state_dbg, HUNT);
    chk("terr_digits", frame_digits, 16'h5555);
    drive(8'h40, 3);

    // reset mid-frame, then a frame without and with a leading blank
    drive(8'h00, SLOT);
    drive(8'h06, SLOT);
    drive(8'h5B, SLOT);
    do_reset();
    chk("trst_digits", frame_digits, 16'h0000);
    chk("trst_state", state_dbg, HUNT);
    snap();
    drive(8'h6F, SLOT); drive(8'h7F, SLOT); drive(8'h07, SLOT); drive(8'h7D, SLOT);
    drive(8'h40, 6);
    chk("trst_noblank_fv", n_fv - s_fv, 0);
    chk("trst_noblank_digits", frame_digits, 16'h0000);
    snap();
    drive_codes(8'h00, 8'h6F, 8'h7F, 8'h07, 8'h7D);
    drive(8'h40, 3);
    chk("t9876_fv_count", n_fv - s_fv, 1);
    chk("t9876_digits", frame_digits, 16'h9876);
    drive(8'h40, 3);

    // 3-cycle glitch inside a slot restarts the slot
    snap();
    drive(8'h00, SLOT);
    drive(8'h06, 2);
    drive(8'h7F, 3);
    drive(8'h06, SLOT);
    drive(8'h40, 3);
    chk("tglitch_sym_count", n_sym - s_sym, 2);
    chk("tglitch_no_glitch_sym", n_sym8 - s_sym8, 0);
    chk("tglitch_last_code", last_code, 4'd1);
    chk("tglitch_state", state_dbg, GET2);
    drive(8'h40, 3);

    // random streams
    held = frame_digits;
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          drive(8'h00, SLOT * $urandom_range(1, 2));
          for (int j = 0; j < 4; j++) drive(PAT_TAB[$urandom_range(0, 9)], SLOT);
        end
        2: begin
          repeat ($urandom_range(1, 4)) drive(rand_pat(), $urandom_range(1, 9));
        end
        default: begin
          seq[0] = 8'h00; seq[1] = 8'h3F; seq[2] = 8'h3E; seq[3] = 8'h79; seq[4] = 8'h50;
          k = $urandom_range(0, 7);
          if (k < 5) seq[k] = rand_pat();
          for (int j = 0; j < 5; j++) drive(seq[j], SLOT);
        end
      endcase
    end
    drive(8'h40, 6);
    if (held == frame_digits) chk("rand_digits_model", frame_digits, e_digits);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
